// File: rtl/cla_nibble_serial_adder_pkg.sv
// cla_nibble_serial_adder_pkg: shared constants, FSM encoding and sizing helper for the serial adder
package cla_nibble_serial_adder_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction
endpackage

// File: rtl/cla_nibble_serial_adder_if.sv
// cla_nibble_serial_adder_if: operand/result valid-ready bundle between a requester and the serial adder
interface cla_nibble_serial_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, s, cout, ovf);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, s, cout, ovf);
endinterface

// File: rtl/cla_nibble_serial_adder_cla.sv
// cla_adder: 4-bit carry-lookahead slice, c3 is the carry out of the top bit
module cla_adder
    import cla_nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             c3
);
    logic [NIB_W-1:0] g, p, c;
    // generate/propagate lookahead, every carry computed directly from cin
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c3   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
    end
endmodule

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder reusing one 4-bit CLA slice over WIDTH/4 cycles, LS nibble first
module cla_nibble_serial_adder
    import cla_nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    cla_nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IW      = idx_width(NIBBLES);

    generate
        if (WIDTH % NIB_W != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d, s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [NIB_W-1:0] slice_s;
    logic             slice_c3;

    cla_adder u_slice (
        .a   (a_sh_q[NIB_W-1:0]),
        .b   (b_sh_q[NIB_W-1:0]),
        .cin (carry_q),
        .s   (slice_s),
        .c3  (slice_c3)
    );

    assign bus.in_ready  = !(state_q == RUN || state_q == DONE);
    assign bus.out_valid = state_q == DONE;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // sequencing: capture operands, step one nibble per cycle, publish result, wait for consumer
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                sum_d[idx_q*NIB_W +: NIB_W] = slice_s;
                carry_d = slice_c3;
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    idx_d   = idx_q;
                    s_d     = sum_d;
                    cout_d  = slice_c3;
                    ovf_d   = slice_c3 ^ (a_msb_q ^ b_msb_q ^ slice_s[NIB_W-1]);
                    state_d = DONE;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: begin
                state_d = IDLE;
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    // state and datapath registers, all cleared by reset so an interrupted operation leaves no trace
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed and randomized checks of the serial adder against an arithmetic model
module tb_cla_nibble_serial_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_adder_if #(.WIDTH(W)) bus ();

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
        int unsigned u;
        int          sv;
        u  = int'(a) + int'(b) + int'(c);
        sv = int'($signed(a)) + int'($signed(b)) + int'(c);
        s  = u[W-1:0];
        co = u[W];
        ov = (sv > 32767) || (sv < -32768);
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input int hold);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n = 0;
        model(a, b, c, es, ec, eo);
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        repeat (hold) step();
        check({tag, "_s"}, 32'(bus.s), 32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        accept(a, b, c);
        wait_result(tag, a, b, c, 0);
    endtask

    initial begin
        logic [W-1:0] s0, ra, rb;
        logic         c0, o0, rc;
        int           rose;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        do_op("carry_nib", 16'h00FF, 16'h0001, 1'b0);
        check("idle_after_pop", 32'(bus.in_ready), 32'd1);
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        do_op("ripple_all", 16'hFFFF, 16'h0000, 1'b1);
        do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
        do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0);

        accept(16'h1357, 16'h2468, 1'b1);
        wait_result("bp_first", 16'h1357, 16'h2468, 1'b1, 0);
        accept(16'hA5A5, 16'h5A5B, 1'b0);
        while (!bus.out_valid) step();
        s0 = bus.s;
        c0 = bus.cout;
        o0 = bus.ovf;
        bus.in_valid = 1'b1;
        bus.a = 16'h4321;
        bus.b = 16'h0F0F;
        bus.cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_s", 32'(bus.s), 32'(s0));
            check("bp_cout", 32'(bus.cout), 32'(c0));
            check("bp_ovf", 32'(bus.ovf), 32'(o0));
        end
        check("bp_s_val", 32'(s0), 32'h0000);
        check("bp_cout_val", 32'(c0), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_release_idle", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("bp_new_accepted", 32'(bus.in_ready), 32'd0);
        wait_result("bp_new", 16'h4321, 16'h0F0F, 1'b1, 0);

        accept(16'h1234, 16'h1111, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_s", 32'(bus.s), 32'd0);
        step();
        rst = 1'b0;
        rose = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.out_valid) rose = 1;
        end
        check("mid_rst_no_valid", 32'(rose), 32'd0);
        do_op("after_rst", 16'h1234, 16'h1111, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            accept(ra, rb, rc);
            wait_result("rand", ra, rb, rc, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
